// File: rtl/mux_oht_pkg.sv
// Shared helpers for the pipelined one-hot mux: tree depth and the
// per-group "more than one select bit set" test.
package mux_oht_pkg;

    function automatic int clog_base(input int width, input int split);
        int lvl;
        int span;
        lvl  = 0;
        span = 1;
        while (span < width) begin
            span = span * split;
            lvl++;
        end
        return lvl;
    endfunction

    // Callers zero-extend their group to 64 bits, so SPLIT is limited to 64.
    function automatic logic onehot_multi(input logic [63:0] vec);
        return (vec & (vec - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/mux_oht_stage.sv
// One pipeline stage: NLEV reduction levels of a SPLIT-ary one-hot mux tree
// followed by a valid/ready register holding data, select and multi-hot flag.
module mux_oht_stage
    import mux_oht_pkg::*;
#(
    parameter type DAT_T          = logic [7:0],
    parameter int  N_IN           = 32,
    parameter int  SPLIT          = 2,
    parameter int  NLEV           = 1,
    parameter int  IMPLEMENTATION = 0,
    localparam int N_OUT          = N_IN / (SPLIT ** NLEV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  DAT_T [0:N_IN-1]       in_dat,
    input  logic [N_IN-1:0]       in_sel,
    input  logic                  in_mul,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output DAT_T [0:N_OUT-1]      out_dat,
    output logic [N_OUT-1:0]      out_sel,
    output logic                  out_mul
);

    for (genvar l = 0; l <= NLEV; l++) begin : lv
        localparam int N = N_IN / (SPLIT ** l);
        DAT_T [0:N-1] dat;
        logic [N-1:0] sel;
        logic         mul;

        if (l == 0) begin : g_in
            assign dat = in_dat;
            assign sel = in_sel;
            assign mul = in_mul;
        end else begin : g_red
            always_comb begin
                dat = '0;
                sel = '0;
                mul = lv[l-1].mul;
                for (int g = 0; g < N; g++) begin
                    for (int j = 0; j < SPLIT; j++) begin
                        // Both styles give the OR of selected entries; 1 maps to AND-OR gates directly.
                        if (IMPLEMENTATION == 0) begin
                            if (lv[l-1].sel[g*SPLIT+j])
                                dat[g] = dat[g] | lv[l-1].dat[g*SPLIT+j];
                        end else begin
                            dat[g] = dat[g] | (lv[l-1].dat[g*SPLIT+j]
                                     & {$bits(DAT_T){lv[l-1].sel[g*SPLIT+j]}});
                        end
                        sel[g] = sel[g] | lv[l-1].sel[g*SPLIT+j];
                    end
                    mul = mul | onehot_multi(64'(lv[l-1].sel[g*SPLIT +: SPLIT]));
                end
            end
        end
    end

    assign in_rdy = !out_vld | out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_sel <= '0;
            out_mul <= 1'b0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            out_dat <= lv[NLEV].dat;
            out_sel <= lv[NLEV].sel;
            out_mul <= lv[NLEV].mul;
        end
    end

endmodule

// File: rtl/mux_oht_pipe.sv
// Pipelined one-hot mux: WIDTH entries reduced through a SPLIT-ary tree,
// registered every PIPE levels, with non-one-hot select detection.
module mux_oht_pipe
    import mux_oht_pkg::*;
#(
    parameter type DAT_T          = logic [8-1:0],
    parameter int  WIDTH          = 32,
    parameter int  SPLIT          = 2,
    parameter int  PIPE           = 1,
    parameter int  IMPLEMENTATION = 0,
    localparam int LEVELS         = clog_base(WIDTH, SPLIT),
    localparam int LATENCY        = (LEVELS + PIPE - 1) / PIPE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                src_vld,
    output logic                src_rdy,
    input  logic [WIDTH-1:0]    src_oht,
    input  DAT_T [0:WIDTH-1]    src_ary,
    output logic                dst_vld,
    input  logic                dst_rdy,
    output DAT_T                dst_dat,
    output logic                dst_err
);

    localparam int NPAD = SPLIT ** LEVELS;

    DAT_T [0:NPAD-1] pad_dat;
    logic [NPAD-1:0] pad_sel;

    always_comb begin
        pad_dat = '0;
        for (int i = 0; i < WIDTH; i++) pad_dat[i] = src_ary[i];
    end

    assign pad_sel = NPAD'(src_oht);

    for (genvar k = 0; k < LATENCY; k++) begin : st
        localparam int NI = NPAD / (SPLIT ** (k * PIPE));
        // The last stage takes whatever levels remain.
        localparam int NL = (LEVELS - k * PIPE < PIPE) ? (LEVELS - k * PIPE) : PIPE;
        localparam int NO = NI / (SPLIT ** NL);

        logic          i_vld, i_rdy, i_mul;
        DAT_T [0:NI-1] i_dat;
        logic [NI-1:0] i_sel;
        logic          o_vld, o_rdy, o_mul;
        DAT_T [0:NO-1] o_dat;
        logic [NO-1:0] o_sel;

        if (k == 0) begin : g_first
            assign i_vld = src_vld;
            assign i_dat = pad_dat;
            assign i_sel = pad_sel;
            assign i_mul = 1'b0;
        end else begin : g_chain
            assign i_vld = st[k-1].o_vld;
            assign i_dat = st[k-1].o_dat;
            assign i_sel = st[k-1].o_sel;
            assign i_mul = st[k-1].o_mul;
        end

        if (k == LATENCY - 1) begin : g_last
            assign o_rdy = dst_rdy;
        end else begin : g_mid
            assign o_rdy = st[k+1].i_rdy;
        end

        mux_oht_stage #(
            .DAT_T          (DAT_T),
            .N_IN           (NI),
            .SPLIT          (SPLIT),
            .NLEV           (NL),
            .IMPLEMENTATION (IMPLEMENTATION)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_vld  (i_vld),
            .in_rdy  (i_rdy),
            .in_dat  (i_dat),
            .in_sel  (i_sel),
            .in_mul  (i_mul),
            .out_vld (o_vld),
            .out_rdy (o_rdy),
            .out_dat (o_dat),
            .out_sel (o_sel),
            .out_mul (o_mul)
        );
    end

    assign src_rdy = st[0].i_rdy;
    assign dst_vld = st[LATENCY-1].o_vld;
    assign dst_dat = st[LATENCY-1].o_dat[0];
    // Gated by valid so an empty output stage never reports an error.
    assign dst_err = st[LATENCY-1].o_vld & (st[LATENCY-1].o_mul | ~st[LATENCY-1].o_sel[0]);

endmodule

// File: tb/tb_mux_oht_pipe.sv
// Self-checking bench for mux_oht_pipe: vector table, random backpressure
// against a behavioural model, reset in flight and a latency sweep.
module tb_mux_oht_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance: WIDTH=32 SPLIT=2 PIPE=2 -> LATENCY=3
    logic             m_src_vld, m_src_rdy, m_dst_vld, m_dst_rdy, m_dst_err;
    logic [31:0]      m_oht;
    logic [0:31][7:0] m_ary;
    logic [7:0]       m_dst_dat;

    mux_oht_pipe #(.WIDTH(32), .SPLIT(2), .PIPE(2)) u_main (
        .clk(clk), .rst_n(rst_n),
        .src_vld(m_src_vld), .src_rdy(m_src_rdy), .src_oht(m_oht), .src_ary(m_ary),
        .dst_vld(m_dst_vld), .dst_rdy(m_dst_rdy), .dst_dat(m_dst_dat), .dst_err(m_dst_err)
    );

    // sweep instances: WIDTH=32 SPLIT=2, PIPE = 1, 3, 5
    logic             s_vld;
    logic [31:0]      s_oht;
    logic [0:31][7:0] s_ary;
    logic             s_rdy  [3];
    logic             s_dvld [3];
    logic [7:0]       s_dat  [3];
    logic             s_err  [3];

    mux_oht_pipe #(.WIDTH(32), .SPLIT(2), .PIPE(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .src_vld(s_vld), .src_rdy(s_rdy[0]), .src_oht(s_oht),
        .src_ary(s_ary), .dst_vld(s_dvld[0]), .dst_rdy(1'b1), .dst_dat(s_dat[0]), .dst_err(s_err[0])
    );
    mux_oht_pipe #(.WIDTH(32), .SPLIT(2), .PIPE(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .src_vld(s_vld), .src_rdy(s_rdy[1]), .src_oht(s_oht),
        .src_ary(s_ary), .dst_vld(s_dvld[1]), .dst_rdy(1'b1), .dst_dat(s_dat[1]), .dst_err(s_err[1])
    );
    mux_oht_pipe #(.WIDTH(32), .SPLIT(2), .PIPE(5)) u_p5 (
        .clk(clk), .rst_n(rst_n), .src_vld(s_vld), .src_rdy(s_rdy[2]), .src_oht(s_oht),
        .src_ary(s_ary), .dst_vld(s_dvld[2]), .dst_rdy(1'b1), .dst_dat(s_dat[2]), .dst_err(s_err[2])
    );

    // padded instance: WIDTH=5 SPLIT=4 -> 16 entries, LEVELS=2, LATENCY=2
    logic            w_vld, w_rdy, w_dvld, w_err;
    logic [4:0]      w_oht;
    logic [0:4][7:0] w_ary;
    logic [7:0]      w_dat;

    mux_oht_pipe #(.WIDTH(5), .SPLIT(4), .PIPE(1)) u_w5 (
        .clk(clk), .rst_n(rst_n), .src_vld(w_vld), .src_rdy(w_rdy), .src_oht(w_oht),
        .src_ary(w_ary), .dst_vld(w_dvld), .dst_rdy(1'b1), .dst_dat(w_dat), .dst_err(w_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [31:0] oht, input logic [0:31][7:0] ary,
                                  output logic [7:0] d, output logic e);
        d = '0;
        for (int i = 0; i < 32; i++) if (oht[i]) d |= ary[i];
        e = ($countones(oht) != 1);
    endfunction

    function automatic logic [0:31][7:0] make_ary(input bit pat);
        logic [0:31][7:0] a;
        for (int i = 0; i < 32; i++) a[i] = pat ? 8'(32'd1 << i) : 8'(i);
        return a;
    endfunction

    typedef struct { logic [7:0] dat; logic err; int acc; } exp_t;
    exp_t q[$];
    exp_t hd;
    bit   chk_lat  = 1'b0;
    bit   rand_rdy = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat;
    logic       prev_err;

    // output scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("src_rdy_vs_full", 32'(m_src_rdy), 32'(!(q.size() == 3 && !m_dst_rdy)));
            if (prev_stall) begin
                chk("stall_vld", 32'(m_dst_vld), 32'd1);
                chk("stall_dat", 32'(m_dst_dat), 32'(prev_dat));
                chk("stall_err", 32'(m_dst_err), 32'(prev_err));
            end
            if (m_dst_vld && m_dst_rdy) begin
                chk("out_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    hd = q.pop_front();
                    chk("out_dat", 32'(m_dst_dat), 32'(hd.dat));
                    chk("out_err", 32'(m_dst_err), 32'(hd.err));
                    if (chk_lat) chk("latency", 32'(cyc - hd.acc), 32'd2);
                end
            end
            prev_stall <= m_dst_vld && !m_dst_rdy;
            prev_dat   <= m_dst_dat;
            prev_err   <= m_dst_err;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_dst_rdy = 1'($urandom_range(0, 1));
        end
    end

    // called and returns at posedge+1
    task automatic send(input logic [31:0] oht, input logic [0:31][7:0] ary,
                        input logic [7:0] ed, input logic ee);
        int n;
        n = 0;
        m_oht = oht;
        m_ary = ary;
        m_src_vld = 1'b1;
        @(negedge clk);
        while (!m_src_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_src_rdy) begin
            chk("send_timeout", 32'(m_src_rdy), 32'd1);
            @(posedge clk);
            #1;
            m_src_vld = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        q.push_back('{ed, ee, cyc});
        m_src_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [31:0] oht; bit pat; logic [7:0] dat; logic err; } vec_t;
    vec_t tbl[9];

    initial begin
        logic [31:0]      r_oht;
        logic [0:31][7:0] r_ary;
        logic [7:0]       r_dat;
        logic             r_err;
        int               t0, cnt;
        int               lat     [3];
        int               lat_exp [3];
        int               w_lat;
        logic [7:0]       sw_exp;

        tbl = '{
            '{32'h0000_0020, 1'b0, 8'h05, 1'b0},
            '{32'h0000_0000, 1'b1, 8'h00, 1'b1},
            '{32'h0000_0003, 1'b1, 8'h03, 1'b1},
            '{32'h8000_0000, 1'b0, 8'h1F, 1'b0},
            '{32'h8000_0001, 1'b0, 8'h1F, 1'b1},
            '{32'hFFFF_FFFF, 1'b1, 8'hFF, 1'b1},
            '{32'h0000_0080, 1'b1, 8'h80, 1'b0},
            '{32'h0000_0C00, 1'b0, 8'h0B, 1'b1},
            '{32'h0000_0100, 1'b1, 8'h00, 1'b0}
        };
        lat_exp = '{5, 2, 1};

        rst_n = 1'b0;
        m_src_vld = 1'b0; m_oht = '0; m_ary = '0; m_dst_rdy = 1'b1;
        s_vld = 1'b0; s_oht = '0; s_ary = '0;
        w_vld = 1'b0; w_oht = '0; w_ary = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dst_vld", 32'(m_dst_vld), 32'd0);
        chk("rst_dst_dat", 32'(m_dst_dat), 32'd0);
        chk("rst_dst_err", 32'(m_dst_err), 32'd0);
        chk("rst_src_rdy", 32'(m_src_rdy), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // one-hot walk, back-to-back
        chk_lat = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 32; i++) send(32'd1 << i, make_ary(1'b0), 8'(i), 1'b0);
        chk("b2b_cycles", 32'(cyc - t0), 32'd32);
        for (int i = 0; i < 9; i++) send(tbl[i].oht, make_ary(tbl[i].pat), tbl[i].dat, tbl[i].err);
        drain();
        chk_lat = 1'b0;

        // random stimulus with random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    r_oht = 32'd1 << $urandom_range(0, 31);
                2:       r_oht = '0;
                default: r_oht = $urandom;
            endcase
            for (int i = 0; i < 32; i++) r_ary[i] = 8'($urandom);
            model(r_oht, r_ary, r_dat, r_err);
            send(r_oht, r_ary, r_dat, r_err);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        m_dst_rdy = 1'b1;
        drain();

        // reset with three items in flight
        m_dst_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(32'd1 << (i + 1), make_ary(1'b0), 8'(i + 1), 1'b0);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("rif_dst_vld", 32'(m_dst_vld), 32'd0);
        chk("rif_dst_dat", 32'(m_dst_dat), 32'd0);
        chk("rif_dst_err", 32'(m_dst_err), 32'd0);
        chk("rif_src_rdy", 32'(m_src_rdy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_dst_rdy = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_dst_vld) cnt++;
        end
        chk("rif_stale_out", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;

        // latency sweep and padded-width case, one item each
        for (int i = 0; i < 32; i++) s_ary[i] = 8'($urandom);
        s_oht = 32'd1 << 19;
        sw_exp = s_ary[19];
        for (int i = 0; i < 5; i++) w_ary[i] = 8'($urandom);
        w_ary[4] = 8'hA5;
        w_oht = 5'b10000;
        s_vld = 1'b1;
        w_vld = 1'b1;
        @(negedge clk);
        chk("sw_src_rdy", 32'({s_rdy[0], s_rdy[1], s_rdy[2], w_rdy}), 32'hF);
        @(posedge clk);
        #1;
        s_vld = 1'b0;
        w_vld = 1'b0;
        t0 = cyc;
        lat = '{0, 0, 0};
        w_lat = 0;
        repeat (12) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (lat[j] == 0 && s_dvld[j]) begin
                    lat[j] = cyc - t0 + 1;
                    chk("sw_dat", 32'(s_dat[j]), 32'(sw_exp));
                    chk("sw_err", 32'(s_err[j]), 32'd0);
                end
            end
            if (w_lat == 0 && w_dvld) begin
                w_lat = cyc - t0 + 1;
                chk("w5_dat", 32'(w_dat), 32'hA5);
                chk("w5_err", 32'(w_err), 32'd0);
            end
        end
        for (int j = 0; j < 3; j++) chk("sw_latency", 32'(lat[j]), 32'(lat_exp[j]));
        chk("w5_latency", 32'(w_lat), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
